// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 matrix keypad scanner with debounce, ghost rejection and ready/ack handshake
// Strobes one active-low column at a time, accumulates a full scan, debounces it and encodes the key.
module keypad_scan #(
  parameter int SCAN_DIV       = 5000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] kp_row,
  output logic [3:0] kp_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pulse,
  output logic       key_ready,
  input  logic       key_ack,
  output logic       overrun
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] DEB_MAX  = SW'(DEBOUNCE_SCANS);

  typedef enum logic {ST_IDLE, ST_HELD} state_t;

  state_t        state, state_next;
  logic [3:0]    row_s1, row_s2;
  logic [DW-1:0] div;
  logic [1:0]    col_idx;
  logic [1:0]    acc_cnt;
  logic [3:0]    acc_code;
  logic          prev_key;
  logic [3:0]    prev_code;
  logic [SW-1:0] stable_cnt;

  logic          sample, scan_end;
  logic [3:0]    pressed;
  logic [2:0]    col_sum;
  logic [3:0]    total;
  logic [1:0]    scan_cnt;
  logic [3:0]    scan_code;
  logic [1:0]    first_row;
  logic          res_key;
  logic [3:0]    res_code;
  logic [SW-1:0] stable_next;
  logic          confirm;
  logic          load_code;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'b00_00: key_map = 4'h1;
      4'b00_01: key_map = 4'h2;
      4'b00_10: key_map = 4'h3;
      4'b00_11: key_map = 4'hA;
      4'b01_00: key_map = 4'h4;
      4'b01_01: key_map = 4'h5;
      4'b01_10: key_map = 4'h6;
      4'b01_11: key_map = 4'hB;
      4'b10_00: key_map = 4'h7;
      4'b10_01: key_map = 4'h8;
      4'b10_10: key_map = 4'h9;
      4'b10_11: key_map = 4'hC;
      4'b11_00: key_map = 4'h0;
      4'b11_01: key_map = 4'hF;
      4'b11_10: key_map = 4'hE;
      default:  key_map = 4'hD;
    endcase
  endfunction

  assign kp_col    = ~(4'b0001 << col_idx);
  assign key_valid = (state == ST_HELD);
  assign sample    = (div == DIV_LAST);
  assign scan_end  = sample && (col_idx == 2'd3);
  assign pressed   = ~row_s2;

  // Fold the current column sample into the running scan totals.
  always_comb begin
    first_row = 2'd0;
    if (pressed[0])      first_row = 2'd0;
    else if (pressed[1]) first_row = 2'd1;
    else if (pressed[2]) first_row = 2'd2;
    else if (pressed[3]) first_row = 2'd3;
    col_sum   = {2'b00, pressed[0]} + {2'b00, pressed[1]}
              + {2'b00, pressed[2]} + {2'b00, pressed[3]};
    total     = {2'b00, acc_cnt} + {1'b0, col_sum};
    scan_cnt  = (total >= 4'd2) ? 2'd2 : total[1:0];
    scan_code = (acc_cnt == 2'd0 && pressed != 4'b0000) ? key_map(first_row, col_idx) : acc_code;
    res_key   = (scan_cnt == 2'd1);
    res_code  = res_key ? scan_code : 4'h0;
    if (res_key == prev_key && res_code == prev_code)
      stable_next = (stable_cnt == DEB_MAX) ? stable_cnt : stable_cnt + SW'(1);
    else
      stable_next = SW'(1);
    confirm = scan_end && (stable_next == DEB_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_code  = 1'b0;
    if (confirm) begin
      if (res_key) begin
        state_next = ST_HELD;
        load_code  = (state == ST_IDLE) || (key_code != res_code);
      end else begin
        state_next = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1     <= 4'b1111;
      row_s2     <= 4'b1111;
      div        <= '0;
      col_idx    <= 2'd0;
      acc_cnt    <= 2'd0;
      acc_code   <= 4'h0;
      prev_key   <= 1'b0;
      prev_code  <= 4'h0;
      stable_cnt <= '0;
      key_code   <= 4'h0;
      key_pulse  <= 1'b0;
      key_ready  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      row_s1 <= kp_row;
      row_s2 <= row_s1;
      if (sample) begin
        div     <= '0;
        col_idx <= col_idx + 2'd1;
        if (scan_end) begin
          acc_cnt    <= 2'd0;
          acc_code   <= 4'h0;
          prev_key   <= res_key;
          prev_code  <= res_code;
          stable_cnt <= stable_next;
        end else begin
          acc_cnt  <= scan_cnt;
          acc_code <= scan_code;
        end
      end else begin
        div <= div + DW'(1);
      end
      key_pulse <= load_code;
      if (load_code) key_code <= res_code;
      // A simultaneous pulse and ack leaves the new key pending.
      key_ready <= key_pulse | (key_ready & ~key_ack);
      if (key_ack)                     overrun <= 1'b0;
      else if (key_pulse && key_ready) overrun <= 1'b1;
    end
  end

endmodule
